// File: rtl/puf_pkg.sv
// Shared types and default parameter values for the ring-oscillator PUF response generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  localparam int DEF_SEL_W     = 5;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_WINDOW    = 256;
  localparam int DEF_SETTLE    = 4;
  localparam int DEF_RESP_BITS = 8;
  localparam int DEF_MARGIN    = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one raw oscillator output, detects rising edges and counts them with saturation.
// Latency: an input edge reaches the counter 2 cycles after it is first sampled.
// Backpressure: none; clr_i has priority over en_i, counting stops at all-ones.
module ro_edge_counter
  import puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized value
  logic [2:0]       sync_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign rise  = sync_q[1] & ~sync_q[2];
  assign cnt_o = cnt_q;

  // Shift the asynchronous input through the synchronizer and edge-history flops
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ro_i};
    end
  end

  // Next count: clear, else saturating increment on a detected rising edge
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/puf_resp_gen.sv
// Sequences oscillator-pair challenges, counts both channels over a window and builds the response word.
// Latency: RESP_BITS*(SETTLE+WINDOW+1) cycles from accepted start to resp_valid.
// Backpressure: holds resp/resp_valid in DONE until resp_ready; PUF_MARGIN_EN adds resp_unstable.
module puf_resp_gen
  import puf_pkg::*;
#(
  parameter int SEL_W     = DEF_SEL_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int RESP_BITS = DEF_RESP_BITS
`ifdef PUF_MARGIN_EN
  ,
  parameter int MARGIN    = DEF_MARGIN
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SEL_W-1:0]     challenge,
  input  logic                 ro_a,
  input  logic                 ro_b,
  output logic [SEL_W-1:0]     sel_a,
  output logic [SEL_W-1:0]     sel_b,
  output logic                 ro_ena,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready
`ifdef PUF_MARGIN_EN
  ,
  output logic [RESP_BITS-1:0] resp_unstable
`endif
);

  localparam int TMR_W = $clog2(max2(WINDOW, SETTLE));
  localparam int KW    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [KW-1:0]        k_q, k_d;
  logic [SEL_W-1:0]     sel_a_q, sel_a_d;
  logic [SEL_W-1:0]     sel_b_q, sel_b_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [CNT_W-1:0]     cnt_a, cnt_b;
  logic                 cnt_clr, cnt_en;

`ifdef PUF_MARGIN_EN
  logic [RESP_BITS-1:0] unst_q, unst_d;
  logic [CNT_W-1:0]     cnt_diff;

  assign cnt_diff      = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
  assign resp_unstable = unst_q;
`endif

  // Counters are cleared during settling so the old pair's edges never leak into a window
  assign cnt_clr = (state_q == ST_SETTLE);
  assign cnt_en  = (state_q == ST_MEASURE);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_i  (ro_a),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_i  (ro_b),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_b)
  );

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;
  assign resp  = resp_q;

  // Next-state, phase timer, select stepping, response bit capture and status outputs
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    k_d        = k_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    resp_d     = resp_q;
`ifdef PUF_MARGIN_EN
    unst_d     = unst_q;
`endif
    ro_ena     = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_SETTLE;
          tmr_d   = TMR_W'(SETTLE - 1);
          k_d     = '0;
          sel_a_d = challenge;
          sel_b_d = challenge + SEL_W'(1);
          resp_d  = '0;
`ifdef PUF_MARGIN_EN
          unst_d  = '0;
`endif
        end
      end
      ST_SETTLE: begin
        ro_ena = 1'b1;
        if (tmr_q == '0) begin
          state_d = ST_MEASURE;
          tmr_d   = TMR_W'(WINDOW - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        ro_ena = 1'b1;
        if (tmr_q == '0) begin
          state_d = ST_COMPARE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COMPARE: begin
        ro_ena      = 1'b1;
        resp_d[k_q] = (cnt_a > cnt_b);
`ifdef PUF_MARGIN_EN
        unst_d[k_q] = (cnt_diff < CNT_W'(MARGIN));
`endif
        if (k_q == KW'(RESP_BITS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          tmr_d   = TMR_W'(SETTLE - 1);
          k_d     = k_q + KW'(1);
          sel_a_d = sel_a_q + SEL_W'(2);
          sel_b_d = sel_b_q + SEL_W'(2);
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial response
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      k_q     <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      resp_q  <= '0;
`ifdef PUF_MARGIN_EN
      unst_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      k_q     <= k_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      resp_q  <= resp_d;
`ifdef PUF_MARGIN_EN
      unst_q  <= unst_d;
`endif
    end
  end

endmodule
